// File: rtl/mem_pkg.sv
// Shared definitions for the two-cache memory arbiter: widths, request field
// layout and the arbiter FSM encoding.
package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int LINE_W = 16;
  localparam int REQ_W  = 1 + DATA_W + ADDR_W;

  // Request layout: {write, data[7:0], address[15:0]}
  localparam int REQ_WRITE_BIT = 24;
  localparam int REQ_DATA_MSB  = 23;
  localparam int REQ_DATA_LSB  = 16;
  localparam int REQ_ADDR_MSB  = 15;
  localparam int REQ_ADDR_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Line address of a request: the byte address with its lowest bit cleared.
  function automatic logic [ADDR_W-1:0] req_line_addr(input logic [REQ_W-1:0] req);
    return {req[REQ_ADDR_MSB:REQ_ADDR_LSB+1], 1'b0};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick. On a tie the port that did not win last time
// is chosen; a lone requester always wins. Purely combinational.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  // Winner index and "someone is asking" flag
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between two caches, one transaction at a
// time, round-robin on contention. Optional write-invalidate broadcast to the
// non-writing cache is compiled in when MEM_ARBITER_INVALIDATE_EN is defined;
// otherwise the invalidate outputs are tied to zero.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [REQ_W-1:0]  c0_memory_request,
  input  logic [REQ_W-1:0]  c1_memory_request,
  input  logic              c0_memory_request_ready,
  input  logic              c1_memory_request_ready,
  output logic [LINE_W-1:0] c0_memory_response,
  output logic [LINE_W-1:0] c1_memory_response,
  output logic              c0_memory_response_ready,
  output logic              c1_memory_response_ready,
  output logic [ADDR_W-1:0] c0_invalidate_address,
  output logic [ADDR_W-1:0] c1_invalidate_address,
  output logic              c0_invalidate_ready,
  output logic              c1_invalidate_ready,
  output logic [REQ_W-1:0]  memory_request,
  output logic              memory_request_ready,
  input  logic [LINE_W-1:0] memory_response,
  input  logic              memory_response_ready
);

  arb_state_e        state_q, state_d;
  logic [REQ_W-1:0]  req_q;
  logic [LINE_W-1:0] line_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              arb_grant;
  logic              arb_valid;
  logic              granted_ready;

  rr_arbiter2 u_rr (
    .req0       (c0_memory_request_ready),
    .req1       (c1_memory_request_ready),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign granted_ready = grant_q ? c1_memory_request_ready : c0_memory_request_ready;

  // Next-state and memory-side outputs
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d              = state_q;
    memory_request       = '0;
    memory_request_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) state_d = ISSUE;
      end
      ISSUE: begin
        memory_request       = req_q;
        memory_request_ready = 1'b1;
        if (memory_response_ready) state_d = RESPOND;
      end
      RESPOND: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        // A request still held after its response must not be served twice.
        if (!granted_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request/response and round-robin history
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: all state is reset, including the data holding registers, so
    // every output is a known 0 the instant reset asserts.
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      line_q       <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      if (state_q == IDLE && arb_valid) begin
        req_q   <= arb_grant ? c1_memory_request : c0_memory_request;
        grant_q <= arb_grant;
      end
      if (state_q == ISSUE && memory_response_ready) line_q <= memory_response;
      if (state_q == RESPOND) last_grant_q <= grant_q;
    end
  end

  // Response pulse to the granted cache, decoded from registered state only
  always_comb begin
    c0_memory_response_ready = (state_q == RESPOND) && !grant_q;
    c1_memory_response_ready = (state_q == RESPOND) &&  grant_q;
    c0_memory_response       = c0_memory_response_ready ? line_q : '0;
    c1_memory_response       = c1_memory_response_ready ? line_q : '0;
  end

`ifdef MEM_ARBITER_INVALIDATE_EN
  logic inv_fire;
  assign inv_fire = (state_q == RESPOND) && req_q[REQ_WRITE_BIT];

  // A write by one cache invalidates the same line in the other cache
  always_comb begin
    c0_invalidate_ready   = 1'b0;
    c1_invalidate_ready   = 1'b0;
    c0_invalidate_address = '0;
    c1_invalidate_address = '0;
    if (inv_fire) begin
      if (grant_q) begin
        c0_invalidate_ready   = 1'b1;
        c0_invalidate_address = req_line_addr(req_q);
      end else begin
        c1_invalidate_ready   = 1'b1;
        c1_invalidate_address = req_line_addr(req_q);
      end
    end
  end
`else
  assign c0_invalidate_ready   = 1'b0;
  assign c1_invalidate_ready   = 1'b0;
  assign c0_invalidate_address = '0;
  assign c1_invalidate_address = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. Expected responses are queued when a
// request is driven and popped by a monitor when a response pulse appears.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_pkg::*;

`ifdef MEM_ARBITER_INVALIDATE_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  typedef struct {
    logic              port;
    logic [LINE_W-1:0] line;
    logic              inv;
    logic [ADDR_W-1:0] inv_addr;
  } exp_t;

  logic              clock;
  logic              reset;
  logic [REQ_W-1:0]  c0_memory_request, c1_memory_request;
  logic              c0_memory_request_ready, c1_memory_request_ready;
  logic [LINE_W-1:0] c0_memory_response, c1_memory_response;
  logic              c0_memory_response_ready, c1_memory_response_ready;
  logic [ADDR_W-1:0] c0_invalidate_address, c1_invalidate_address;
  logic              c0_invalidate_ready, c1_invalidate_ready;
  logic [REQ_W-1:0]  memory_request;
  logic              memory_request_ready;
  logic [LINE_W-1:0] memory_response;
  logic              memory_response_ready;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t             exp_q[$];
  logic [REQ_W-1:0] issued_q[$];
  int  resp_cnt[2];
  bit  mem_enable  = 1'b1;
  int  mem_latency = 0;
  bit  stray_pulse = 1'b0;

  mem_arbiter dut (
    .clock                    (clock),
    .reset                    (reset),
    .c0_memory_request        (c0_memory_request),
    .c1_memory_request        (c1_memory_request),
    .c0_memory_request_ready  (c0_memory_request_ready),
    .c1_memory_request_ready  (c1_memory_request_ready),
    .c0_memory_response       (c0_memory_response),
    .c1_memory_response       (c1_memory_response),
    .c0_memory_response_ready (c0_memory_response_ready),
    .c1_memory_response_ready (c1_memory_response_ready),
    .c0_invalidate_address    (c0_invalidate_address),
    .c1_invalidate_address    (c1_invalidate_address),
    .c0_invalidate_ready      (c0_invalidate_ready),
    .c1_invalidate_ready      (c1_invalidate_ready),
    .memory_request           (memory_request),
    .memory_request_ready     (memory_request_ready),
    .memory_response          (memory_response),
    .memory_response_ready    (memory_response_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory contents model: line data derived from the address.
  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {a[7:0] + 8'h2B, a[15:8]};
  endfunction

  function automatic logic [REQ_W-1:0] mk_req(input logic wr, input logic [7:0] d,
                                              input logic [15:0] a);
    return {wr, d, a};
  endfunction

  // Memory responder: answers after mem_latency extra ISSUE cycles.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    memory_response_ready = 1'b0;
    memory_response = '0;
    forever begin
      @(negedge clock);
      memory_response_ready = 1'b0;
      memory_response = '0;
      if (stray_pulse) begin
        memory_response_ready = 1'b1;
        memory_response = 16'hDEAD;
        stray_pulse = 1'b0;
      end else if (mem_enable && memory_request_ready) begin
        if (wait_cnt >= mem_latency) begin
          memory_response_ready = 1'b1;
          memory_response = line_of(memory_request[15:0]);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: logs issued requests, checks every response pulse against the
  // scoreboard and checks idle buses are zero.
  initial begin : monitor
    exp_t e;
    logic mrr_prev;
    logic [LINE_W-1:0] got;
    mrr_prev = 1'b0;
    resp_cnt[0] = 0;
    resp_cnt[1] = 0;
    forever begin
      @(negedge clock);
      if (memory_request_ready && !mrr_prev) issued_q.push_back(memory_request);
      mrr_prev = memory_request_ready;
      if (c0_memory_response_ready || c1_memory_response_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_response: c0_ready=%b c1_ready=%b, no response expected",
                   c0_memory_response_ready, c1_memory_response_ready);
        end else begin
          e = exp_q.pop_front();
          if ({c1_memory_response_ready, c0_memory_response_ready} !== (e.port ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL resp_port: ready {c1,c0}=%b, expected port %0d",
                     {c1_memory_response_ready, c0_memory_response_ready}, e.port);
          end
          got = e.port ? c1_memory_response : c0_memory_response;
          n_cmp++;
          if (got !== e.line) begin
            n_bad++;
            $display("FAIL resp_data: port %0d got %h, expected %h", e.port, got, e.line);
          end
          n_cmp++;
          if ({c0_invalidate_ready, c1_invalidate_ready} !==
              {e.inv && e.port, e.inv && !e.port}) begin
            n_bad++;
            $display("FAIL inv_ready: {c0,c1}=%b, expected %b",
                     {c0_invalidate_ready, c1_invalidate_ready}, {e.inv && e.port, e.inv && !e.port});
          end
          n_cmp++;
          if ((e.port ? c0_invalidate_address : c1_invalidate_address) !== (e.inv ? e.inv_addr : 16'h0)) begin
            n_bad++;
            $display("FAIL inv_addr: got %h, expected %h",
                     e.port ? c0_invalidate_address : c1_invalidate_address, e.inv ? e.inv_addr : 16'h0);
          end
          resp_cnt[e.port]++;
        end
      end else begin
        n_cmp++;
        if ({c0_invalidate_ready, c1_invalidate_ready} !== 2'b00) begin
          n_bad++;
          $display("FAIL stray_invalidate: {c0,c1}=%b without a response, expected 00",
                   {c0_invalidate_ready, c1_invalidate_ready});
        end
      end
      n_cmp++;
      if ((!c0_memory_response_ready && c0_memory_response !== '0) ||
          (!c1_memory_response_ready && c1_memory_response !== '0) ||
          (!c0_invalidate_ready && c0_invalidate_address !== '0) ||
          (!c1_invalidate_ready && c1_invalidate_address !== '0)) begin
        n_bad++;
        $display("FAIL idle_bus_zero: resp0=%h resp1=%h inv0=%h inv1=%h, expected 0 where not ready",
                 c0_memory_response, c1_memory_response, c0_invalidate_address, c1_invalidate_address);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push_exp(input logic port, input logic [LINE_W-1:0] line,
                          input logic inv, input logic [ADDR_W-1:0] inv_addr);
    exp_t e;
    e.port = port;
    e.line = line;
    e.inv = inv;
    e.inv_addr = inv ? inv_addr : 16'h0;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int port, input logic [REQ_W-1:0] req, input logic rdy);
    if (port == 0) begin
      c0_memory_request = req;
      c0_memory_request_ready = rdy;
    end else begin
      c1_memory_request = req;
      c1_memory_request_ready = rdy;
    end
  endtask

  task automatic wait_resp(input int port, input int target, input int budget, input string name);
    int k = 0;
    while (resp_cnt[port] < target && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (resp_cnt[port] < target) begin
      n_bad++;
      $display("FAIL %s_timeout: port %0d responses %0d, expected %0d within %0d cycles",
               name, port, resp_cnt[port], target, budget);
    end
  endtask

  task automatic check_issued(input string name, input logic [REQ_W-1:0] req);
    logic [REQ_W-1:0] got;
    n_cmp++;
    if (issued_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no memory request issued, expected %h", name, req);
    end else begin
      got = issued_q.pop_front();
      if (got !== req) begin
        n_bad++;
        $display("FAIL %s: memory_request %h, expected %h", name, got, req);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({memory_request_ready, memory_request} !== '0) begin
      n_bad++;
      $display("FAIL %s_mem_side: ready=%b request=%h, expected 0", name, memory_request_ready, memory_request);
    end
    n_cmp++;
    if ({c0_memory_response_ready, c1_memory_response_ready, c0_memory_response, c1_memory_response} !== '0) begin
      n_bad++;
      $display("FAIL %s_resp_side: r0=%b r1=%b d0=%h d1=%h, expected 0", name,
               c0_memory_response_ready, c1_memory_response_ready, c0_memory_response, c1_memory_response);
    end
    n_cmp++;
    if ({c0_invalidate_ready, c1_invalidate_ready, c0_invalidate_address, c1_invalidate_address} !== '0) begin
      n_bad++;
      $display("FAIL %s_inv_side: i0=%b i1=%b a0=%h a1=%h, expected 0", name,
               c0_invalidate_ready, c1_invalidate_ready, c0_invalidate_address, c1_invalidate_address);
    end
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_req(0, '0, 1'b0);
    set_req(1, '0, 1'b0);
    #2;
    reset = 1'b1;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();
    check_all_zero("after_reset");
  endtask

  task automatic test_single_read();
    logic [REQ_W-1:0] req;
    int target;
    req = mk_req(1'b0, 8'd0, 16'd12);
    mem_latency = 2;
    target = resp_cnt[0] + 1;
    push_exp(1'b0, 16'h3700, 1'b0, 16'h0);
    set_req(0, req, 1'b1);
    @(posedge clock); #1;
    n_cmp++;
    if (memory_request_ready !== 1'b1 || memory_request !== req) begin
      n_bad++;
      $display("FAIL issue_latency: ready=%b request=%h, expected 1 / %h",
               memory_request_ready, memory_request, req);
    end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (c0_memory_response_ready !== 1'b1 || c0_memory_response !== 16'h3700) begin
      n_bad++;
      $display("FAIL read_pulse_time: ready=%b data=%h, expected 1 / 3700",
               c0_memory_response_ready, c0_memory_response);
    end
    wait_resp(0, target, 20, "single_read");
    set_req(0, req, 1'b0);
    @(posedge clock); #1;
    n_cmp++;
    if (c0_memory_response_ready !== 1'b0 || memory_request_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_width: resp_ready=%b mem_ready=%b after pulse, expected 0 / 0",
               c0_memory_response_ready, memory_request_ready);
    end
    check_issued("single_read_req", req);
    step();
    step();
  endtask

  task automatic test_simultaneous();
    logic [REQ_W-1:0] r0, r1;
    int t0, t1;
    apply_reset();
    mem_latency = 1;
    r0 = mk_req(1'b0, 8'h00, 16'h0200);
    r1 = mk_req(1'b0, 8'h00, 16'h0304);
    t0 = resp_cnt[0] + 1;
    t1 = resp_cnt[1] + 1;
    push_exp(1'b0, line_of(16'h0200), 1'b0, 16'h0);
    push_exp(1'b1, line_of(16'h0304), 1'b0, 16'h0);
    set_req(0, r0, 1'b1);
    set_req(1, r1, 1'b1);
    wait_resp(0, t0, 20, "simul_port0");
    set_req(0, r0, 1'b0);
    wait_resp(1, t1, 20, "simul_port1");
    set_req(1, r1, 1'b0);
    check_issued("simul_first", r0);
    check_issued("simul_second", r1);
    step();
    step();
  endtask

  task automatic test_fairness();
    logic [REQ_W-1:0] r[2];
    int base[2];
    mem_latency = 0;
    r[0] = mk_req(1'b0, 8'h00, 16'h0100);
    r[1] = mk_req(1'b0, 8'h00, 16'h0202);
    base[0] = resp_cnt[0];
    base[1] = resp_cnt[1];
    for (int k = 0; k < 4; k++) push_exp(k[0], line_of(r[k%2][15:0]), 1'b0, 16'h0);
    set_req(0, r[0], 1'b1);
    set_req(1, r[1], 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_resp(k % 2, base[k%2] + k/2 + 1, 20, "fairness");
      set_req(k % 2, r[k%2], 1'b0);
      step();
      step();
      if (k < 2) set_req(k % 2, r[k%2], 1'b1);
    end
    for (int k = 0; k < 4; k++) check_issued("fairness_order", r[k%2]);
    step();
  endtask

  task automatic test_turnaround();
    logic [REQ_W-1:0] req;
    int target;
    mem_latency = 0;
    req = mk_req(1'b0, 8'h00, 16'h0555);
    target = resp_cnt[1] + 1;
    push_exp(1'b1, line_of(16'h0555), 1'b0, 16'h0);
    set_req(1, req, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (c1_memory_response_ready !== 1'b1 || c1_memory_response !== line_of(16'h0555)) begin
      n_bad++;
      $display("FAIL min_turnaround: ready=%b data=%h, expected 1 / %h",
               c1_memory_response_ready, c1_memory_response, line_of(16'h0555));
    end
    wait_resp(1, target, 10, "turnaround");
    set_req(1, req, 1'b0);
    check_issued("turnaround_req", req);
    step();
    step();
  endtask

  task automatic test_write_invalidate();
    logic [REQ_W-1:0] w1, w0;
    int t0, t1;
    mem_latency = 1;
    w1 = mk_req(1'b1, 8'd56, 16'd13);
    w0 = mk_req(1'b1, 8'hA5, 16'h0031);
    t1 = resp_cnt[1] + 1;
    push_exp(1'b1, line_of(16'd13), INV_ON, 16'd12);
    set_req(1, w1, 1'b1);
    wait_resp(1, t1, 20, "write_port1");
    set_req(1, w1, 1'b0);
    check_issued("write_port1_req", w1);
    step();
    step();
    t0 = resp_cnt[0] + 1;
    push_exp(1'b0, line_of(16'h0031), INV_ON, 16'h0030);
    set_req(0, w0, 1'b1);
    wait_resp(0, t0, 20, "write_port0");
    set_req(0, w0, 1'b0);
    check_issued("write_port0_req", w0);
    step();
    step();
  endtask

  task automatic test_held_request();
    logic [REQ_W-1:0] r, r2;
    int t;
    mem_latency = 1;
    r  = mk_req(1'b0, 8'h00, 16'h0040);
    r2 = mk_req(1'b0, 8'h00, 16'h0042);
    t = resp_cnt[0] + 1;
    push_exp(1'b0, line_of(16'h0040), 1'b0, 16'h0);
    set_req(0, r, 1'b1);
    wait_resp(0, t, 20, "held_first");
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (memory_request_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL held_no_reissue: cycle %0d memory_request_ready=%b, expected 0",
                 k, memory_request_ready);
      end
    end
    set_req(0, r, 1'b0);
    step();
    step();
    t = resp_cnt[0] + 1;
    push_exp(1'b0, line_of(16'h0042), 1'b0, 16'h0);
    set_req(0, r2, 1'b1);
    wait_resp(0, t, 20, "held_next");
    set_req(0, r2, 1'b0);
    check_issued("held_first_req", r);
    check_issued("held_next_req", r2);
    step();
    step();
  endtask

  task automatic test_reset_in_issue();
    logic [REQ_W-1:0] r, r1;
    int k, t;
    mem_enable = 1'b0;
    r  = mk_req(1'b0, 8'h00, 16'h0077);
    r1 = mk_req(1'b0, 8'h00, 16'h0123);
    set_req(0, r, 1'b1);
    k = 0;
    while (memory_request_ready !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    n_cmp++;
    if (memory_request_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_issue_setup: memory_request_ready=%b, expected 1", memory_request_ready);
    end
    reset = 1'b1;
    #1;
    check_all_zero("reset_in_issue");
    set_req(0, r, 1'b0);
    step();
    step();
    reset = 1'b0;
    check_issued("aborted_req", r);
    stray_pulse = 1'b1;
    step();
    step();
    step();
    n_cmp++;
    if (memory_request_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_ignored: memory_request_ready=%b, expected 0", memory_request_ready);
    end
    mem_enable = 1'b1;
    mem_latency = 0;
    t = resp_cnt[1] + 1;
    push_exp(1'b1, line_of(16'h0123), 1'b0, 16'h0);
    set_req(1, r1, 1'b1);
    wait_resp(1, t, 20, "post_reset");
    set_req(1, r1, 1'b0);
    check_issued("post_reset_req", r1);
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_turnaround();
    test_write_invalidate();
    test_held_request();
    test_reset_in_issue();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d responses still outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
